// File: rtl/lm32_ram_pkg.sv
// Shared types and helpers for the lm32 RAM flush controller.
package lm32_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Highest address of a RAM with 2^aw entries.
  function automatic logic [31:0] last_addr(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/lm32_ram_flush_ctrl.sv
// Write-port controller that sweeps a dual-port RAM to a fill value on request.
// Macro LM32_RAM_FLUSH_ON_RESET_EN makes reset start a sweep instead of idling.
module lm32_ram_flush_ctrl
  import lm32_ram_pkg::*;
#(
  parameter int                    addr_width = 8,
  parameter int                    data_width = 32,
  parameter logic [data_width-1:0] fill_value = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  we_i,
  input  logic [addr_width-1:0] waddr_i,
  input  logic [data_width-1:0] wdata_i,
  input  logic [addr_width-1:0] raddr_i,
  output logic [data_width-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_we_o,
  output logic [addr_width-1:0] ram_waddr_o,
  output logic [data_width-1:0] ram_wdata_o,
  output logic [addr_width-1:0] ram_raddr_o,
  input  logic [data_width-1:0] ram_rdata_i
);

  localparam logic [addr_width-1:0] cnt_last = addr_width'(last_addr(addr_width));

`ifdef LM32_RAM_FLUSH_ON_RESET_EN
  localparam state_t reset_state = ST_SWEEP;
`else
  localparam state_t reset_state = ST_IDLE;
`endif

  state_t                state;
  state_t                state_next;
  logic [addr_width-1:0] cnt;
  logic [addr_width-1:0] cnt_next;
  logic                  done_next;

  // rvalid tracks the state the RAM's registered read address will be sampled in.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= reset_state;
      cnt      <= '0;
      done_o   <= 1'b0;
      rvalid_o <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      done_o   <= done_next;
      rvalid_o <= (state_next != ST_SWEEP);
    end
  end

  // A flush always restarts from address 0, even on the final sweep address.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flush_i) begin
          state_next = ST_SWEEP;
          cnt_next   = '0;
        end
      end
      ST_SWEEP: begin
        if (flush_i) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt + addr_width'(1);
          if (cnt == cnt_last) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy_o = (state == ST_SWEEP);

  always_comb begin
    ram_we_o    = we_i;
    ram_waddr_o = waddr_i;
    ram_wdata_o = wdata_i;
    if (busy_o) begin
      ram_we_o    = 1'b1;
      ram_waddr_o = cnt;
      ram_wdata_o = fill_value;
    end
  end

  assign ram_raddr_o = raddr_i;
  assign rdata_o     = ram_rdata_i;

endmodule
